uart_rx_8n1: RTL and testbench
==============================

// Module: uart_rx_8n1
// PURPOSE
//  UART 8N1 receiver, the receive-side counterpart of uart_tx_8n1. Oversamples the uartrx
//  pin on the system clock, frames start/data/stop bits and hands each byte to a
//  downstream consumer (echo/command FSM) over a valid/ready handshake.
//  Reports framing errors and overruns.
// PARAMETERS
//  CLKS_PER_BIT  1250  system clocks per UART bit (12 MHz / 9600 baud); legal range >= 8
//  HALF          CLKS_PER_BIT/2  derived localparam: mid-bit sample offset; not overridable
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  rst        in   1  synchronous, active-high reset
//  rx         in   1  asynchronous serial input; idle high
//  rxbyte     out  8  received byte; valid while rxvalid=1
//  rxvalid    out  1  byte available; held until accepted
//  rxready    in   1  consumer accepts byte on a cycle with rxvalid=1
//  frame_err  out  1  one-cycle pulse: stop bit sampled low
//  overrun    out  1  sticky: unaccepted byte overwritten; cleared only by rst
//  busy       out  1  high in every state except IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; rxbyte=8'h00; rxvalid, frame_err, overrun, busy = 0.
//    Sync flops are preset to 1.
//  - rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s.
//  - bit counter cnt: 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); wraps to 0.
//    The index counter counts 0..7.
//  - IDLE: rx_s==0 -> START with cnt=0.
//  - START: at cnt==HALF sample rx_s.
//    - If 1: false start (glitch); return to IDLE.
//    - If 0: continue. At cnt==CLKS_PER_BIT-1 go to DATA with idx=0.
//  - DATA: sample at cnt==HALF and shift the bit in LSB first (shift right, bit into [7]).
//    - At cnt wrap with idx==7 -> STOP; otherwise idx++.
//  - STOP: sample at cnt==HALF.
//    - If 1: load rxbyte and set rxvalid=1 on the next edge, then go to IDLE.
//      IDLE is entered at mid-stop so a back-to-back start edge is caught.
//    - If 0: frame_err=1 for one cycle; byte discarded; rxvalid and rxbyte unchanged;
//      go to WAIT_IDLE.
//  - WAIT_IDLE: remain until rx_s==1, then go to IDLE. A break condition therefore
//    yields exactly one frame_err.
//  - Handshake: rxvalid && rxready on a cycle clears rxvalid on the next edge unless a
//    new byte loads that same edge.
//  - Simultaneous load and accept: new byte loaded, rxvalid stays 1, no overrun.
//  - Load while rxvalid=1 and rxready=0: rxbyte is overwritten, rxvalid stays 1,
//    overrun is set.
//  - Latency: the falling start edge on rx is seen in IDLE 2 clocks later. rxvalid rises
//    on the cycle after the stop sample (about 9.5 bit times after the start edge, plus 3).
//  - rst mid-frame: returns to IDLE on the next edge and discards the partial byte.
//    The receiver then resynchronises on the next low rx_s, so a frame that is in
//    progress can produce a frame_err.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined:
//    - Each bit (start, data, stop) is sampled at cnt==HALF-1, HALF and HALF+1.
//    - The 2-of-3 majority is the bit value; the decision is made at cnt==HALF+1.
//    - All "at HALF" actions above move to HALF+1.
//    - Requires CLKS_PER_BIT >= 8.
//  Undefined: single sample at cnt==HALF. No vote flops are synthesized.
// TESTING (sim with CLKS_PER_BIT=16)
//  1. Frame 0x55, rxready=0 -> rxbyte=8'h55, rxvalid=1 held, frame_err=0, overrun=0.
//     Then rxready=1 for 1 cycle -> rxvalid=0 next cycle.
//  2. Back-to-back frames 0xA5, 0x3C with no idle gap, rxready=1 -> two rxvalid pulses.
//     The bytes are A5 then 3C, overrun=0.
//  3. Stop bit driven 0, then line held low 40 clocks -> exactly one frame_err pulse.
//     No rxvalid; busy=1 until rx returns high.
//  4. rx low for 3 clocks only -> no rxvalid, no frame_err; busy returns to 0
//     by cnt==HALF+3.
//  5. Two frames 0x11, 0x22 with rxready=0 -> rxbyte=8'h22, rxvalid=1, overrun=1.
//     overrun stays 1 after the accept; it is cleared by rst.
//  6. rst asserted during data bit 3 -> all outputs at reset values.
//     The next clean frame 0xC3 is received correctly.
//     With UART_RX_MAJORITY_EN, a 1-clock glitch at cnt==HALF of bit 2 is rejected.

Source files
------------

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver with valid/ready byte output, framing-error pulse and sticky overrun.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote at HALF-1/HALF/HALF+1.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxbyte,
    output logic       rxvalid,
    input  logic       rxready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
    localparam int SAMP = HALF + 1;
`else
    localparam int SAMP = HALF;
`endif
    localparam logic [CW-1:0] CNT_SAMP = CW'(SAMP);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d, rxbyte_q, rxbyte_d;
    logic          rxvalid_q, rxvalid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic          rx_s, samp_now, wrap, bit_val, load;

    assign rx_s     = sync2_q;
    assign samp_now = cnt_q == CNT_SAMP;
    assign wrap     = cnt_q == CNT_LAST;

`ifdef UART_RX_MAJORITY_EN
    logic v0_q, v0_d, v1_q, v1_d;
    always_comb begin
        v0_d = (cnt_q == CW'(HALF - 1)) ? rx_s : v0_q;
        v1_d = (cnt_q == CW'(HALF)) ? rx_s : v1_q;
    end
    assign bit_val = (v0_q & v1_q) | (v0_q & rx_s) | (v1_q & rx_s);
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q <= 1'b1;
            v1_q <= 1'b1;
        end else begin
            v0_q <= v0_d;
            v1_q <= v1_d;
        end
    end
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            rxbyte_q    <= 8'h00;
            rxvalid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rxbyte_q    <= rxbyte_d;
            rxvalid_q   <= rxvalid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Stop bit returns to IDLE at mid-bit so a back-to-back start edge is not missed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = rx_s ? IDLE : START;
            START:     state_d = (samp_now && bit_val) ? IDLE : (wrap ? DATA : START);
            DATA:      state_d = (wrap && idx_q == 3'd7) ? STOP : DATA;
            STOP:      state_d = samp_now ? (bit_val ? IDLE : WAIT_IDLE) : STOP;
            WAIT_IDLE: state_d = rx_s ? IDLE : WAIT_IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        load        = state_q == STOP && samp_now && bit_val;
        cnt_d       = (state_q == IDLE || state_q == WAIT_IDLE || wrap) ? '0 : cnt_q + CW'(1);
        idx_d       = state_q != DATA ? 3'd0 : (wrap ? idx_q + 3'd1 : idx_q);
        shift_d     = (state_q == DATA && samp_now) ? {bit_val, shift_q[7:1]} : shift_q;
        rxbyte_d    = load ? shift_q : rxbyte_q;
        rxvalid_d   = load | (rxvalid_q & ~rxready);
        overrun_d   = overrun_q | (load & rxvalid_q & ~rxready);
        frame_err_d = state_q == STOP && samp_now && !bit_val;
        busy        = state_q != IDLE;
    end

    assign rxbyte    = rxbyte_q;
    assign rxvalid   = rxvalid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: scoreboard bench for uart_rx_8n1 at CLKS_PER_BIT=16.
// Stimulus pushes expected bytes; a negedge monitor pops and compares on each accept.
module tb_uart_rx_8n1;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rxready = 1'b0;
    logic [7:0] rxbyte;
    logic       rxvalid, frame_err, overrun, busy;

    int         checks = 0;
    int         fails = 0;
    int         fe_seen = 0;
    int         fe_exp = 0;
    bit         rnd_ready = 0;
    logic [7:0] exp_q[$];

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rxbyte(rxbyte), .rxvalid(rxvalid),
        .rxready(rxready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && frame_err) fe_seen++;
        if (!rst && rxvalid && rxready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_byte: got %02h with no byte expected", rxbyte);
            end else begin
                check("byte", int'(rxbyte), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (rnd_ready) rxready = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    // Frame slot k: 0 = start, 1..8 = data LSB first, 9 = stop. glitch_k inverts one clock at mid-slot.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int glitch_k, input int max_ticks);
        logic [9:0] f;
        int n;
        f = {stop_bit, b, 1'b0};
        n = 0;
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < CPB; j++) begin
                if (n >= max_ticks) return;
                rx = (k == glitch_k && j == CPB / 2) ? ~f[k] : f[k];
                if (rnd_ready) rxready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] b;
        logic       good;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        check("reset_rxbyte", int'(rxbyte), 0);
        check("reset_rxvalid", int'(rxvalid), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_busy", int'(busy), 0);

        // 1: single frame held until accepted
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, -1, 1000);
        idle(5);
        check("t1_rxvalid_held", int'(rxvalid), 1);
        check("t1_rxbyte", int'(rxbyte), 8'h55);
        check("t1_overrun", int'(overrun), 0);
        rxready = 1'b1;
        tick();
        rxready = 1'b0;
        check("t1_rxvalid_cleared", int'(rxvalid), 0);

        // 2: back-to-back frames, consumer always ready
        rxready = 1'b1;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        send_frame(8'hA5, 1'b1, -1, 1000);
        send_frame(8'h3C, 1'b1, -1, 1000);
        drain(50);
        check("t2_overrun", int'(overrun), 0);
        check("t2_fe_count", fe_seen, fe_exp);

        // 3: break condition gives exactly one framing error
        send_frame(8'h00, 1'b0, -1, 1000);
        fe_exp++;
        for (int i = 0; i < 40; i++) tick();
        check("t3_busy_in_break", int'(busy), 1);
        idle(6);
        check("t3_busy_after_break", int'(busy), 0);
        check("t3_fe_count", fe_seen, fe_exp);

        // 4: short low glitch is a false start
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (CPB / 2 + 6) tick();
        check("t4_busy", int'(busy), 0);
        check("t4_fe_count", fe_seen, fe_exp);

        // 5: overwrite of an unaccepted byte
        rxready = 1'b0;
        send_frame(8'h11, 1'b1, -1, 1000);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, -1, 1000);
        idle(4);
        check("t5_rxbyte", int'(rxbyte), 8'h22);
        check("t5_rxvalid", int'(rxvalid), 1);
        check("t5_overrun", int'(overrun), 1);
        rxready = 1'b1;
        tick();
        rxready = 1'b0;
        tick();
        check("t5_overrun_sticky", int'(overrun), 1);
        check("t5_drained", exp_q.size(), 0);

        // 6: reset during data bit 3, then a clean frame
        send_frame(8'hC3, 1'b1, -1, 4 * CPB + CPB / 2);
        rst = 1'b1;
        rx = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("t6_rxbyte", int'(rxbyte), 0);
        check("t6_rxvalid", int'(rxvalid), 0);
        check("t6_frame_err", int'(frame_err), 0);
        check("t6_overrun", int'(overrun), 0);
        check("t6_busy", int'(busy), 0);
        idle(2 * CPB);
        rxready = 1'b1;
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, -1, 1000);
        drain(50);
`ifdef UART_RX_MAJORITY_EN
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 3, 1000);
        drain(50);
`endif

        // random frames with random consumer backpressure
        rnd_ready = 1;
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            good = ($urandom_range(0, 7) != 0);
            if (good) exp_q.push_back(b);
            else fe_exp++;
            send_frame(b, good, -1, 1000);
            idle(good ? $urandom_range(0, 2) * (CPB / 2) : CPB + $urandom_range(0, CPB));
        end
        rnd_ready = 0;
        rxready = 1'b1;
        drain(100);
        idle(CPB);
        check("rnd_fe_count", fe_seen, fe_exp);
        check("rnd_overrun", int'(overrun), 0);
        check("rnd_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
